ram_1p_req_adapter: RTL and testbench
=====================================

Name: ram_1p_req_adapter

Overview:
- Valid/ready request front-end that sits directly upstream of the generic single-port SRAM (prim_generic_ram_1p).
- Drives the RAM's req/write/addr/wdata/wmask pins and captures read data one cycle after a read.
- Returns in-order responses through a credit-protected response FIFO.
- Optionally converts partial-mask writes into read-modify-write (RMW) sequences, so ECC-wide arrays always see full-word writes.

Parameters:
- Width, 32, data word width in bits.
- Depth, 128, RAM words; Aw = $clog2(Depth).
- RspDepth, 4, response FIFO entries; minimum 2.
- RmwEn, 1, 1 = partial-mask writes become RMW; 0 = wmask is passed straight through to the RAM.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  Aw  word address.
- req_wdata_i  in  Width  write data.
- req_wmask_i  in  Width  bit-granular write mask.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid and ready are both high.
- rsp_rdata_o  out  Width  read data; 0 for write responses.
- rsp_write_o  out  1  1 = response belongs to a write.
- ram_req_o  out  1  to RAM req_i.
- ram_write_o  out  1  to RAM write_i.
- ram_addr_o  out  Aw  to RAM addr_i.
- ram_wdata_o  out  Width  to RAM wdata_i.
- ram_wmask_o  out  Width  to RAM wmask_i.
- ram_rdata_i  in  Width  from RAM rdata_o; valid the cycle after a read req.

Behaviour:
- Clock and reset: clock is clk_i; reset is rst_ni, synchronous and active-low.
- Reset state:
  - FSM = IDLE; FIFO empty; pending-response flag pend = 0.
  - While rst_ni = 0: req_ready_o = 0, rsp_valid_o = 0, ram_req_o = 0, ram_write_o = 0. ram_addr/wdata/wmask = 0, rsp_rdata_o = 0, rsp_write_o = 0.
- Credit rule: req_ready_o = (state == IDLE) && (fifo_cnt + pend < RspDepth).
  - Same-cycle dequeue is deliberately ignored (conservative).
  - RspDepth = 4 sustains one request per cycle when rsp_ready_i = 1.
- IDLE, accepted request in cycle N:
  - ram_req_o = 1 combinationally in N, with ram_addr_o = req_addr_i.
  - Read: ram_write_o = 0. In N+1, ram_rdata_i is pushed into the FIFO with rsp_write = 0.
  - Full write, or partial write with RmwEn = 0: ram_write_o = 1, wdata/wmask passed through. In N+1, entry {rdata = 0, rsp_write = 1} is pushed.
  - Partial write with RmwEn = 1:
    - Cycle N: issue a read to the same address; latch addr, wdata and wmask; go to RMW_WR.
  - Every accepted request sets pend for cycle N+1. The push happens at the end of N+1, so rsp_valid_o rises in N+2.
  - Uniform latency preserves ordering.
- RMW_WR (one cycle, N+1):
  - ram_req_o = 1, ram_write_o = 1, ram_wmask_o = all ones.
  - ram_wdata_o = (wdata & wmask) | (ram_rdata_i & ~wmask).
  - req_ready_o = 0.
  - Push {0, 1} at the end of N+1; return to IDLE.
- FIFO:
  - Registered output: rsp_valid_o = !empty.
  - Head entry held stable while rsp_valid_o && !rsp_ready_i.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by the credit rule. Add an assertion that push && full never occurs.
- Full-mask definition: req_wmask_i == all ones. A mask of 0 is a partial write: with RmwEn = 1 the RMW rewrites the old data; with RmwEn = 0 it is passed through.
- Reset mid-RMW:
  - RAM write suppressed in the reset cycle.
  - The pending response is discarded; the FIFO is flushed.
  - The RAM contents at that address are unchanged.
- Add an assertion that ram_req_o is never high in two consecutive cycles without an accept or RMW_WR.

Test Plan:
- Reset, then write addr 5 = 0xDEADBEEF with full mask, then read addr 5:
  - Write response {rsp_write = 1, rdata = 0} in N+2.
  - Read response rdata = 0xDEADBEEF, two cycles after its accept.
- RmwEn = 1: addr 3 preloaded with 0x11223344; write 0xAABBCCDD with mask 0x0000FFFF:
  - ram_req_o high for 2 consecutive cycles: a read, then a write with mask 0xFFFFFFFF and wdata 0x1122CCDD.
  - req_ready_o low in the second cycle.
  - A later read of addr 3 returns 0x1122CCDD.
- Back-to-back reads of addrs 0..7 with rsp_ready_i = 1 and RspDepth = 4:
  - One accept per cycle.
  - Responses arrive in order, two cycles after each accept.
- Hold rsp_ready_i = 0 and issue 6 reads:
  - Exactly 4 are accepted; req_ready_o stays 0 afterwards.
  - rsp_rdata_o stays stable.
  - Releasing rsp_ready_i drains 4 responses in order, then accepts resume.
- Assert rst_ni = 0 during RMW_WR:
  - No RAM write that cycle; the target word keeps its old value.
  - FIFO empty; rsp_valid_o = 0 in the cycle after reset deasserts.
- RmwEn = 0 partial write with mask 0x000000FF:
  - A single RAM cycle with ram_wmask_o = 0x000000FF; no read is issued.

Source files
------------

// File: rtl/ram_1p_req_adapter.sv
// Valid/ready request front-end for a single-port SRAM: in-order responses through
// a credit-protected FIFO, with optional read-modify-write for partial-mask writes.

module ram_1p_req_adapter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic push,
    input logic full,
    input logic ram_req,
    input logic accept,
    input logic rmw_wr
);
    // The credit rule must make FIFO overflow unreachable.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));

    // The RAM is only ever driven by a fresh accept or the write half of an RMW.
    a_ram_req_source: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ram_req |-> (accept || rmw_wr));
endmodule

module ram_1p_req_adapter #(
    parameter int Width    = 32,
    parameter int Depth    = 128,
    parameter int RspDepth = 4,
    parameter bit RmwEn    = 1'b1,
    localparam int Aw      = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_write_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);
    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    state_e            state_r, state_next_s;
    logic              ready_s, accept_s, full_mask_s, rmw_start_s;
    logic [CntW:0]     credit_used_s;
    logic [Aw-1:0]     addr_r;
    logic [Width-1:0]  wdata_r, wmask_r, merged_s;
    logic              pend_r, pend_write_r;
    logic [Width:0]    fifo_mem_r [RspDepth];
    logic [PtrW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CntW-1:0]   cnt_r;
    logic              push_s, pop_s, empty_s, full_s;
    logic [Width:0]    push_data_s, head_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(RspDepth - 1)) begin
            return '0;
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    // Same-cycle dequeue is not credited: conservative but still one request per cycle.
    assign credit_used_s = {1'b0, cnt_r} + (CntW + 1)'(pend_r);
    assign ready_s       = (state_r == ST_IDLE) && (credit_used_s < (CntW + 1)'(RspDepth));
    assign accept_s      = rst_ni && req_valid_i && ready_s;
    assign full_mask_s   = (req_wmask_i == {Width{1'b1}});
    assign rmw_start_s   = accept_s && req_write_i && !full_mask_s && RmwEn;
    assign merged_s      = (wdata_r & wmask_r) | (ram_rdata_i & ~wmask_r);

    assign empty_s = (cnt_r == CntW'(0));
    assign full_s  = (cnt_r == CntW'(RspDepth));
    assign push_s  = pend_r;
    assign pop_s   = !empty_s && rsp_ready_i;
    assign head_s  = fifo_mem_r[rd_ptr_r];

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rmw_start_s) begin
                    state_next_s = ST_RMW_WR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RMW_WR: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Pending-response flag and RMW operand capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_r       <= 1'b0;
            pend_write_r <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            wmask_r      <= '0;
        end else begin
            pend_r       <= accept_s;
            pend_write_r <= accept_s && req_write_i;
            if (rmw_start_s) begin
                addr_r  <= req_addr_i;
                wdata_r <= req_wdata_i;
                wmask_r <= req_wmask_i;
            end
        end
    end

    // Response entry: write responses carry zero data.
    always_comb begin
        push_data_s = '0;
        if (pend_write_r) begin
            push_data_s = {1'b1, {Width{1'b0}}};
        end else begin
            push_data_s = {1'b0, ram_rdata_i};
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_s && !pop_s) begin
                cnt_r <= cnt_r + CntW'(1);
            end else if (pop_s && !push_s) begin
                cnt_r <= cnt_r - CntW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_write_o = 1'b0;
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (!rst_ni) begin
            ram_req_o = 1'b0;
        end else begin
            req_ready_o = ready_s;
            if (!empty_s) begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = head_s[Width-1:0];
                rsp_write_o = head_s[Width];
            end else begin
                rsp_valid_o = 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ram_req_o  = 1'b1;
                        ram_addr_o = req_addr_i;
                        if (req_write_i && !rmw_start_s) begin
                            ram_write_o = 1'b1;
                            ram_wdata_o = req_wdata_i;
                            ram_wmask_o = req_wmask_i;
                        end else begin
                            ram_write_o = 1'b0;
                        end
                    end else begin
                        ram_req_o = 1'b0;
                    end
                end
                ST_RMW_WR: begin
                    ram_req_o   = 1'b1;
                    ram_write_o = 1'b1;
                    ram_addr_o  = addr_r;
                    ram_wdata_o = merged_s;
                    ram_wmask_o = {Width{1'b1}};
                end
                default: ram_req_o = 1'b0;
            endcase
        end
    end

    ram_1p_req_adapter_chk u_chk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (push_s),
        .full    (full_s),
        .ram_req (ram_req_o),
        .accept  (accept_s),
        .rmw_wr  (state_r == ST_RMW_WR)
    );
endmodule

// File: tb/tb_ram_1p_req_adapter.sv
// Bench for ram_1p_req_adapter: vector table, directed corner sequences and random
// traffic scored against a memory/queue reference model.
module tb_ram_1p_req_adapter;
    localparam int W     = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [W-1:0]  wmask;
        logic [W-1:0]  exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, mem_load;
    logic req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write;
    logic ram_req, ram_write;
    logic [AW-1:0] req_addr, ram_addr;
    logic [W-1:0]  req_wdata, req_wmask, rsp_rdata, ram_wdata, ram_wmask, ram_rdata;
    logic [W-1:0]  mem [DEPTH];

    logic req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_write0;
    logic ram_req0, ram_write0;
    logic [AW-1:0] req_addr0, ram_addr0;
    logic [W-1:0]  req_wdata0, req_wmask0, rsp_rdata0, ram_wdata0, ram_wmask0, ram_rdata0;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int rsp_seen = 0;
    bit sb_en = 1'b0;
    bit lat_chk = 1'b0;
    logic [W-1:0] ref_mem [DEPTH];
    logic [W:0]   exp_q [$];
    int           acc_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_1p_req_adapter #(.Width(W), .Depth(DEPTH), .RspDepth(4), .RmwEn(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_write_o(rsp_write), .ram_req_o(ram_req), .ram_write_o(ram_write),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
        .ram_rdata_i(ram_rdata)
    );

    ram_1p_req_adapter #(.Width(W), .Depth(DEPTH), .RspDepth(4), .RmwEn(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
        .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_wmask_i(req_wmask0),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
        .rsp_write_o(rsp_write0), .ram_req_o(ram_req0), .ram_write_o(ram_write0),
        .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata0), .ram_wmask_o(ram_wmask0),
        .ram_rdata_i(ram_rdata0)
    );

    function automatic logic [W-1:0] pat(input int a);
        return 32'hA5000000 ^ (32'(a) * 32'h00010203);
    endfunction

    // Behavioural single-port SRAM with bit mask and one-cycle read latency.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
        end else begin
            if (ram_req && ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            if (ram_req && !ram_write) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: requests update a reference memory at accept time; responses pop in order.
    task automatic monitor();
        logic [W:0] e;
        int a;
        forever begin
            @(negedge clk);
            if (rst_n && sb_en) begin
                if (req_valid && req_ready) begin
                    if (req_write) begin
                        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                        exp_q.push_back({1'b1, 32'h0000_0000});
                    end else begin
                        exp_q.push_back({1'b0, ref_mem[req_addr]});
                    end
                    acc_q.push_back(cyc);
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_seen++;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("sb_rdata", rsp_rdata, e[W-1:0]);
                        chk("sb_write", 32'(rsp_write), 32'(e[W]));
                        if (lat_chk) chk("sb_latency", 32'(cyc - a), 32'd2);
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] m, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                done = 1'b1;
            end
            step();
        end
        req_valid = 1'b0;
        if (!done) chk("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rsp(input logic [W-1:0] exp_d, input logic exp_w, input int acc, input string nm);
        int seen;
        seen = -1;
        for (int i = 0; i < 32 && seen < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                chk({nm, "_rdata"}, rsp_rdata, exp_d);
                chk({nm, "_write"}, 32'(rsp_write), 32'(exp_w));
            end
        end
        if (seen < 0) chk({nm, "_timeout"}, 32'd1, 32'd0);
        else chk({nm, "_latency"}, 32'(seen - acc), 32'd2);
        step();
    endtask

    initial begin
        vec_t tbl [9];
        int acc, acc_cnt, base;
        bit hs;

        tbl[0] = '{1'b1, 7'd5,   32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000};
        tbl[1] = '{1'b0, 7'd5,   32'h00000000, 32'h00000000, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 7'd5,   32'h12345678, 32'hFF00FF00, 32'h00000000};
        tbl[3] = '{1'b0, 7'd5,   32'h00000000, 32'h00000000, 32'h12AD56EF};
        tbl[4] = '{1'b1, 7'd5,   32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        tbl[5] = '{1'b0, 7'd5,   32'h00000000, 32'h00000000, 32'h12AD56EF};
        tbl[6] = '{1'b1, 7'd127, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h00000000};
        tbl[7] = '{1'b0, 7'd127, 32'h00000000, 32'h00000000, 32'hCAFEF00D};
        tbl[8] = '{1'b0, 7'd0,   32'h00000000, 32'h00000000, 32'hA5000000};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        fork
            monitor();
        join_none

        // Reset with a request already presented: nothing may leak out.
        rst_n = 1'b0; mem_load = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd5; req_wdata = 32'h12345678; req_wmask = 32'hFFFFFFFF;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wmask0 = '0;
        rsp_ready0 = 1'b1; ram_rdata0 = '0;
        step(); step();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_wmask", ram_wmask, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_write", 32'(rsp_write), 32'd0);
        step();
        req_valid = 1'b0; mem_load = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        sb_en = 1'b1; lat_chk = 1'b1;

        // Vector table: one request at a time, response two cycles after accept.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, acc);
            wait_rsp(tbl[i].exp_rdata, tbl[i].wr, acc, $sformatf("vec%0d", i));
        end

        // RMW detail: read then full-mask merged write, with a read held off in between.
        issue(1'b1, 7'd3, 32'h11223344, 32'hFFFFFFFF, acc);
        wait_rsp(32'h0, 1'b1, acc, "pre3");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd3; req_wdata = 32'hAABBCCDD; req_wmask = 32'h0000FFFF;
        @(negedge clk);
        chk("rmw_c1_ready", 32'(req_ready), 32'd1);
        chk("rmw_c1_ram_req", 32'(ram_req), 32'd1);
        chk("rmw_c1_ram_write", 32'(ram_write), 32'd0);
        chk("rmw_c1_ram_addr", 32'(ram_addr), 32'd3);
        step();
        req_write = 1'b0;
        @(negedge clk);
        chk("rmw_c2_ready", 32'(req_ready), 32'd0);
        chk("rmw_c2_ram_req", 32'(ram_req), 32'd1);
        chk("rmw_c2_ram_write", 32'(ram_write), 32'd1);
        chk("rmw_c2_ram_addr", 32'(ram_addr), 32'd3);
        chk("rmw_c2_ram_wmask", ram_wmask, 32'hFFFFFFFF);
        chk("rmw_c2_ram_wdata", ram_wdata, 32'h1122CCDD);
        step();
        @(negedge clk);
        chk("rmw_c3_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        repeat (4) step();
        issue(1'b0, 7'd3, 32'h0, 32'h0, acc);
        wait_rsp(32'h1122CCDD, 1'b0, acc, "rmw_readback");

        // Back-to-back reads at full rate.
        base = rsp_seen;
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = AW'(i);
            @(negedge clk);
            chk("b2b_ready", 32'(req_ready), 32'd1);
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();
        chk("b2b_rsp_count", 32'(rsp_seen - base), 32'd8);

        // Backpressure: credits stop acceptance at four outstanding responses.
        lat_chk = 1'b0; rsp_ready = 1'b0; acc_cnt = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd16;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hs = req_ready;
            if (rsp_valid && exp_q.size() > 0) chk("stall_head", rsp_rdata, exp_q[0][W-1:0]);
            step();
            if (hs) begin
                acc_cnt++;
                req_addr = req_addr + 7'd1;
            end
        end
        chk("stall_accepts", 32'(acc_cnt), 32'd4);
        @(negedge clk);
        chk("stall_ready_low", 32'(req_ready), 32'd0);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && acc_cnt < 6; i++) begin
            @(negedge clk);
            hs = req_ready;
            step();
            if (hs) begin
                acc_cnt++;
                req_addr = req_addr + 7'd1;
            end
        end
        req_valid = 1'b0;
        chk("stall_resume_accepts", 32'(acc_cnt), 32'd6);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset during the write half of an RMW.
        issue(1'b1, 7'd9, 32'h0BADF00D, 32'hFFFFFFFF, acc);
        wait_rsp(32'h0, 1'b1, acc, "pre9");
        sb_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd9; req_wdata = 32'hFFFFFFFF; req_wmask = 32'hFFFF0000;
        @(negedge clk);
        chk("rstrmw_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rstrmw_ram_req", 32'(ram_req), 32'd0);
        chk("rstrmw_ram_write", 32'(ram_write), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstrmw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstrmw_mem_kept", mem[9], 32'h0BADF00D);
        step();
        sb_en = 1'b1; lat_chk = 1'b1;
        issue(1'b0, 7'd9, 32'h0, 32'h0, acc);
        wait_rsp(32'h0BADF00D, 1'b0, acc, "rstrmw_readback");

        // Pass-through instance: a partial write is a single RAM cycle.
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 7'd12;
        req_wdata0 = 32'h13579BDF; req_wmask0 = 32'h000000FF;
        @(negedge clk);
        chk("nrmw_ready", 32'(req_ready0), 32'd1);
        chk("nrmw_ram_req", 32'(ram_req0), 32'd1);
        chk("nrmw_ram_write", 32'(ram_write0), 32'd1);
        chk("nrmw_ram_addr", 32'(ram_addr0), 32'd12);
        chk("nrmw_ram_wmask", ram_wmask0, 32'h000000FF);
        chk("nrmw_ram_wdata", ram_wdata0, 32'h13579BDF);
        step();
        req_valid0 = 1'b0;
        @(negedge clk);
        chk("nrmw_no_read", 32'(ram_req0), 32'd0);
        step();
        @(negedge clk);
        chk("nrmw_rsp_valid", 32'(rsp_valid0), 32'd1);
        chk("nrmw_rsp_write", 32'(rsp_write0), 32'd1);
        chk("nrmw_rsp_rdata", rsp_rdata0, 32'd0);
        step();

        // Random traffic on a small address window against the scoreboard.
        lat_chk = 1'b0; hs = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!req_valid || hs) begin
                req_valid = ($urandom_range(3) != 0);
                req_write = 1'($urandom_range(1));
                req_addr  = AW'($urandom_range(15));
                req_wdata = $urandom();
                case ($urandom_range(3))
                    0:       req_wmask = 32'hFFFFFFFF;
                    1:       req_wmask = 32'h00000000;
                    default: req_wmask = $urandom();
                endcase
            end
            rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            hs = req_valid && req_ready;
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
